// File: rtl/grid_write_arbiter.sv
// Grid memory write-port arbiter: round-robin sharing between snake/food/eraser writers plus a
// full-board clear sweep. Define FIXED_PRIO_EN for fixed priority (lowest index wins).
module grid_write_arbiter #(
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 16,
   parameter int COORD_W = 4,
   parameter int CELL_W  = 2,
   parameter int NREQ    = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*COORD_W-1:0]  req_x,
   input  logic [NREQ*COORD_W-1:0]  req_y,
   input  logic [NREQ*CELL_W-1:0]   req_data,
   output logic [NREQ-1:0]          gnt,
   input  logic                     clear_start,
   output logic                     clear_busy,
   output logic                     clear_done,
   output logic                     mem_we,
   output logic [COORD_W-1:0]       mem_x,
   output logic [COORD_W-1:0]       mem_y,
   output logic [CELL_W-1:0]        mem_data,
   output logic                     oob_err
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TOTAL = GRID_W * GRID_H;
   localparam int CNT_W = $clog2(TOTAL) + 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]         state;
   logic [NREQ-1:0]    gnt_c;
   logic               any_gnt;
   logic [PTR_W-1:0]   gnt_idx;
   logic [CNT_W-1:0]   sweep_cnt;
   logic [COORD_W-1:0] sel_x;
   logic [COORD_W-1:0] sel_y;
   logic [CELL_W-1:0]  sel_data;
   logic               in_range;
   logic               sweep_last;
   logic               arb_en;

   // Handshake: requester i transfers in any cycle where req[i] && gnt[i]; it holds req and
   // its x/y/data stable until then and may change them on the edge that ends the grant cycle.
   assign arb_en = !reset && (state == ST_IDLE) && !clear_start;

`ifdef FIXED_PRIO_EN
   always_comb begin
      gnt_c   = '0;
      any_gnt = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (arb_en && !any_gnt && req[k]) begin
            any_gnt  = 1'b1;
            gnt_idx  = PTR_W'(k);
            gnt_c[k] = 1'b1;
         end
      end
   end
`else
   logic [PTR_W-1:0] rr_ptr;

   // Search starts at rr_ptr and wraps; the first requester found wins.
   always_comb begin
      gnt_c   = '0;
      any_gnt = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (arb_en && !any_gnt && req[(int'(rr_ptr) + k) % NREQ]) begin
            any_gnt = 1'b1;
            gnt_idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
            gnt_c[(int'(rr_ptr) + k) % NREQ] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (any_gnt) begin
         if (gnt_idx == PTR_W'(NREQ - 1)) rr_ptr <= '0;
         else                            rr_ptr <= gnt_idx + PTR_W'(1);
      end
   end
`endif

   assign gnt        = gnt_c;
   assign sel_x      = req_x[int'(gnt_idx) * COORD_W +: COORD_W];
   assign sel_y      = req_y[int'(gnt_idx) * COORD_W +: COORD_W];
   assign sel_data   = req_data[int'(gnt_idx) * CELL_W +: CELL_W];
   assign in_range   = (int'(sel_x) < GRID_W) && (int'(sel_y) < GRID_H);
   assign sweep_last = (sweep_cnt == CNT_W'(TOTAL - 1));
   assign clear_busy = (state == ST_CLEAR);

   // During the sweep mem_x/mem_y double as the raster position of the write on the port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         mem_we     <= 1'b0;
         mem_x      <= '0;
         mem_y      <= '0;
         mem_data   <= '0;
         clear_done <= 1'b0;
         oob_err    <= 1'b0;
         sweep_cnt  <= '0;
      end else begin
         mem_we     <= 1'b0;
         clear_done <= 1'b0;
         oob_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clear_start) begin
                  state     <= ST_CLEAR;
                  mem_we    <= 1'b1;
                  mem_x     <= '0;
                  mem_y     <= '0;
                  mem_data  <= '0;
                  sweep_cnt <= '0;
               end else if (any_gnt) begin
                  if (in_range) begin
                     mem_we   <= 1'b1;
                     mem_x    <= sel_x;
                     mem_y    <= sel_y;
                     mem_data <= sel_data;
                  end else begin
                     oob_err <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               if (sweep_last) begin
                  state      <= ST_IDLE;
                  clear_done <= 1'b1;
               end else begin
                  mem_we    <= 1'b1;
                  mem_data  <= '0;
                  sweep_cnt <= sweep_cnt + CNT_W'(1);
                  if (int'(mem_x) == GRID_W - 1) begin
                     mem_x <= '0;
                     mem_y <= mem_y + COORD_W'(1);
                  end else begin
                     mem_x <= mem_x + COORD_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
